// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Multi-cycle fetch/decode/execute sequencer with 8x16 register file.
// Revision : 1.0
// ============================================================================
module control_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Run,
    output logic        IReq,
    output logic [6:0]  IAddr,
    input  logic        IAck,
    input  logic [15:0] IData,
    output logic [1:0]  Cond,
    output logic [3:0]  Op_C,
    output logic [15:0] Reg1,
    output logic [15:0] Reg2,
    output logic [6:0]  Ld_Sh,
    input  logic [15:0] Alu_Out,
    input  logic [3:0]  Alu_Flag,
    output logic        DReq,
    output logic        DWe,
    output logic [6:0]  DAddr,
    output logic [15:0] DWData,
    input  logic        DAck,
    input  logic [15:0] DRData,
    output logic        Halt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [15:0] C_HALT_INSTR = 16'hFFFF;
    localparam logic [3:0]  C_OP_LDI_A   = 4'h6;
    localparam logic [3:0]  C_OP_MOV     = 4'h7;
    localparam logic [3:0]  C_OP_CMP     = 4'hB;
    localparam logic [3:0]  C_OP_LDI_B   = 4'hC;
    localparam logic [3:0]  C_OP_LOAD    = 4'hD;
    localparam logic [3:0]  C_OP_STORE   = 4'hE;
    localparam logic [3:0]  C_OP_SKIP    = 4'hF;

    state_t      state_q, state_d;
    logic [6:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [3:0]  f_q, f_d;
    logic [1:0]  cond_q, cond_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] reg1_q, reg1_d;
    logic [15:0] reg2_q, reg2_d;
    logic [6:0]  ld_sh_q, ld_sh_d;
    logic        wb_we_q, wb_we_d;
    logic [2:0]  wb_sel_q, wb_sel_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        f_we_q, f_we_d;
    logic [3:0]  f_new_q, f_new_d;
    logic        cond_ok;

    // Flag register layout is {N,Z,C,V}
    always_comb begin
        cond_ok = 1'b1;
        case (ir_q[15:14])
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = f_q[2];
            2'b10:   cond_ok = ~f_q[2];
            default: cond_ok = f_q[3];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        regs_d    = regs_q;
        f_d       = f_q;
        cond_d    = cond_q;
        op_d      = op_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        ld_sh_d   = ld_sh_q;
        wb_we_d   = wb_we_q;
        wb_sel_d  = wb_sel_q;
        wb_data_d = wb_data_q;
        f_we_d    = f_we_q;
        f_new_d   = f_new_q;

        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (IAck) begin
                    if (IData == C_HALT_INSTR) begin
                        state_d = S_HALT;
                    end else begin
                        ir_d    = IData;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                // A failed condition is folded into the skip opcode so EXEC sees no work
                cond_d  = ir_q[15:14];
                op_d    = cond_ok ? ir_q[13:10] : C_OP_SKIP;
                reg1_d  = regs_q[ir_q[9:7]];
                reg2_d  = regs_q[ir_q[6:4]];
                ld_sh_d = ir_q[6:0];
                wb_we_d = 1'b0;
                f_we_d  = 1'b0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d   = S_WB;
                wb_sel_d  = ir_q[9:7];
                wb_data_d = Alu_Out;
                f_new_d   = Alu_Flag;
                case (op_q)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA: begin
                        wb_we_d = 1'b1;
                        f_we_d  = 1'b1;
                    end
                    C_OP_CMP: begin
                        f_we_d = 1'b1;
                    end
                    C_OP_LDI_A, C_OP_LDI_B: begin
                        wb_we_d   = 1'b1;
                        wb_data_d = {9'b0, ld_sh_q};
                    end
                    C_OP_MOV: begin
                        wb_we_d   = 1'b1;
                        wb_data_d = reg2_q;
                    end
                    C_OP_LOAD, C_OP_STORE: begin
                        state_d = S_MEM;
                    end
                    default: begin
                    end
                endcase
            end
            S_MEM: begin
                if (DAck) begin
                    state_d = S_WB;
                    if (op_q == C_OP_LOAD) begin
                        wb_we_d   = 1'b1;
                        wb_sel_d  = ir_q[6:4];
                        wb_data_d = DRData;
                    end
                end
            end
            S_WB: begin
                if (wb_we_q) regs_d[wb_sel_q] = wb_data_q;
                if (f_we_q)  f_d = f_new_q;
                wb_we_d = 1'b0;
                f_we_d  = 1'b0;
                pc_d    = pc_q + 7'd1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (!Run) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            regs_q    <= '{default: '0};
            f_q       <= '0;
            cond_q    <= '0;
            op_q      <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            ld_sh_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_sel_q  <= '0;
            wb_data_q <= '0;
            f_we_q    <= 1'b0;
            f_new_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            regs_q    <= regs_d;
            f_q       <= f_d;
            cond_q    <= cond_d;
            op_q      <= op_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            ld_sh_q   <= ld_sh_d;
            wb_we_q   <= wb_we_d;
            wb_sel_q  <= wb_sel_d;
            wb_data_q <= wb_data_d;
            f_we_q    <= f_we_d;
            f_new_q   <= f_new_d;
        end
    end

    // Memory address/data come straight from the operand latches, stable through MEM
    assign IReq   = (state_q == S_FETCH);
    assign IAddr  = pc_q;
    assign Cond   = cond_q;
    assign Op_C   = op_q;
    assign Reg1   = reg1_q;
    assign Reg2   = reg2_q;
    assign Ld_Sh  = ld_sh_q;
    assign DReq   = (state_q == S_MEM);
    assign DWe    = DReq && (op_q == C_OP_STORE);
    assign DAddr  = reg1_q[6:0];
    assign DWData = reg2_q;
    assign Halt   = (state_q == S_HALT);

endmodule
`default_nettype wire
